// File: rtl/vxe_cu_pkg.sv
// vxe_cu_pkg: shared opcode, error-code and FSM encodings for the CU decode stage
package vxe_cu_pkg;
    localparam logic [4:0] OP_NOP      = 5'h00;
    localparam logic [4:0] OP_JMP      = 5'h01;
    localparam logic [4:0] OP_SYNC     = 5'h02;
    localparam logic [4:0] OP_DONE     = 5'h03;
    localparam logic [4:0] OP_VEC_BASE = 5'h08;

    localparam logic [1:0] ERR_FETCH   = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_SYNC, S_DRAIN, S_RESTART} state_t;
    typedef enum logic [1:0] {EX_JUMP, EX_DONE, EX_ERR} exit_t;
endpackage

// File: rtl/vxe_cu_op_classify.sv
// vxe_cu_op_classify: combinational decode of a command opcode into its class
module vxe_cu_op_classify
    import vxe_cu_pkg::*;
(
    input  logic [4:0] op,
    output logic       is_nop,
    output logic       is_jmp,
    output logic       is_sync,
    output logic       is_done,
    output logic       is_vec,
    output logic       is_illegal
);
    assign is_nop     = op == OP_NOP;
    assign is_jmp     = op == OP_JMP;
    assign is_sync    = op == OP_SYNC;
    assign is_done    = op == OP_DONE;
    assign is_vec     = op >= OP_VEC_BASE;
    assign is_illegal = !is_vec && op > OP_DONE;
endmodule

// File: rtl/vxe_cu_decode_unit.sv
// vxe_cu_decode_unit: CU decode/dispatch stage; runs control-flow commands, forwards vector commands
module vxe_cu_decode_unit
    import vxe_cu_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_start,
    input  logic [36:0] i_start_addr,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic [36:0] o_err_addr,
    output logic        o_fu_start,
    output logic [36:0] o_fu_start_addr,
    output logic        o_fu_stop_drain,
    input  logic        i_fu_busy,
    input  logic [36:0] i_fetch_addr,
    input  logic [63:0] i_fetch_data,
    input  logic        i_fetch_vld,
    input  logic        i_fetch_err,
    output logic        o_fetch_rd,
    output logic [63:0] o_cmd,
    output logic        o_cmd_vld,
    input  logic        i_cmd_rdy,
    input  logic        i_vpus_busy
);
    state_t      state, state_d;
    exit_t       exit_q, exit_d;
    logic [36:0] tgt_q, tgt_d, start_addr_d, eaddr_d;
    logic [1:0]  code_d;
    logic        start_d, stop_d, done_d, err_d, vec_pop, slot_free;
    logic        is_nop, is_jmp, is_sync, is_done, is_vec, is_illegal;

    vxe_cu_op_classify u_cls (
        .op         (i_fetch_data[63:59]),
        .is_nop     (is_nop),
        .is_jmp     (is_jmp),
        .is_sync    (is_sync),
        .is_done    (is_done),
        .is_vec     (is_vec),
        .is_illegal (is_illegal)
    );

    assign slot_free = !o_cmd_vld || i_cmd_rdy;
    assign o_busy    = (state != S_IDLE) || o_cmd_vld;

    always_comb begin
        state_d      = state;
        exit_d       = exit_q;
        tgt_d        = tgt_q;
        start_d      = 1'b0;
        start_addr_d = o_fu_start_addr;
        stop_d       = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        code_d       = o_err_code;
        eaddr_d      = o_err_addr;
        o_fetch_rd   = 1'b0;
        vec_pop      = 1'b0;
        if (i_abort && (state == S_RUN || state == S_SYNC)) begin
            code_d  = ERR_ABORT;
            stop_d  = 1'b1;
            exit_d  = EX_ERR;
            state_d = S_DRAIN;
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    start_d      = 1'b1;
                    start_addr_d = i_start_addr;
                    state_d      = S_RUN;
                end
                S_RUN: if (i_fetch_vld) begin
                    // fetch errors outrank whatever the opcode field says
                    if (i_fetch_err || is_illegal) begin
                        o_fetch_rd = 1'b1;
                        code_d     = i_fetch_err ? ERR_FETCH : ERR_ILLEGAL;
                        eaddr_d    = i_fetch_addr;
                        stop_d     = 1'b1;
                        exit_d     = EX_ERR;
                        state_d    = S_DRAIN;
                    end else if (is_vec) begin
                        o_fetch_rd = slot_free;
                        vec_pop    = slot_free;
                    end else if (is_jmp) begin
                        o_fetch_rd = 1'b1;
                        tgt_d      = i_fetch_data[36:0];
                        stop_d     = 1'b1;
                        exit_d     = EX_JUMP;
                        state_d    = S_DRAIN;
                    end else if (is_sync) begin
                        o_fetch_rd = 1'b1;
                        state_d    = S_SYNC;
                    end else if (is_done) begin
                        o_fetch_rd = 1'b1;
                        stop_d     = 1'b1;
                        exit_d     = EX_DONE;
                        state_d    = S_DRAIN;
                    end else begin
                        o_fetch_rd = is_nop;
                    end
                end
                S_SYNC: if (!o_cmd_vld && !i_vpus_busy) state_d = S_RUN;
                // the stop pulse is still high on the first drain cycle, so it can never exit there
                S_DRAIN: if (!o_fu_stop_drain && !i_fu_busy && !o_cmd_vld) begin
                    state_d = exit_q == EX_JUMP ? S_RESTART : S_IDLE;
                    done_d  = exit_q == EX_DONE;
                    err_d   = exit_q == EX_ERR;
                end
                S_RESTART: begin
                    start_d      = 1'b1;
                    start_addr_d = tgt_q;
                    state_d      = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= S_IDLE;
            exit_q          <= EX_JUMP;
            tgt_q           <= '0;
            o_fu_start      <= 1'b0;
            o_fu_start_addr <= '0;
            o_fu_stop_drain <= 1'b0;
            o_done          <= 1'b0;
            o_err           <= 1'b0;
            o_err_code      <= '0;
            o_err_addr      <= '0;
            o_cmd           <= '0;
            o_cmd_vld       <= 1'b0;
        end else begin
            state           <= state_d;
            exit_q          <= exit_d;
            tgt_q           <= tgt_d;
            o_fu_start      <= start_d;
            o_fu_start_addr <= start_addr_d;
            o_fu_stop_drain <= stop_d;
            o_done          <= done_d;
            o_err           <= err_d;
            o_err_code      <= code_d;
            o_err_addr      <= eaddr_d;
            if (vec_pop) o_cmd <= i_fetch_data;
            o_cmd_vld       <= vec_pop || (o_cmd_vld && !i_cmd_rdy);
        end
    end
endmodule

// File: tb/tb_vxe_cu_decode_unit.sv
// tb_vxe_cu_decode_unit: directed self-checking bench for the CU decode/dispatch stage
module tb_vxe_cu_decode_unit;
    logic        clk = 1'b0, nrst = 1'b0;
    logic        i_start = 1'b0, i_abort = 1'b0, i_fu_busy = 1'b0;
    logic [36:0] i_start_addr = '0, i_fetch_addr = '0;
    logic [63:0] i_fetch_data = '0;
    logic        i_fetch_vld = 1'b0, i_fetch_err = 1'b0, i_cmd_rdy = 1'b1, i_vpus_busy = 1'b0;
    logic        o_busy, o_done, o_err, o_fu_start, o_fu_stop_drain, o_fetch_rd, o_cmd_vld;
    logic [1:0]  o_err_code;
    logic [36:0] o_err_addr, o_fu_start_addr;
    logic [63:0] o_cmd;
    int total = 0, bad = 0, hs = 0;

    localparam logic [63:0] VA   = 64'h4000_0000_0000_00A1;
    localparam logic [63:0] VB   = 64'h4800_0000_0000_00B2;
    localparam logic [63:0] DONE = 64'h1800_0000_0000_0000;
    localparam logic [63:0] SYNC = 64'h1000_0000_0000_0000;
    localparam logic [63:0] JMP  = 64'h0800_0000_0000_2000;
    localparam logic [63:0] ILL  = 64'h2800_0000_0000_0000;

    vxe_cu_decode_unit dut (
        .clk(clk), .nrst(nrst), .i_start(i_start), .i_start_addr(i_start_addr), .i_abort(i_abort),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code), .o_err_addr(o_err_addr),
        .o_fu_start(o_fu_start), .o_fu_start_addr(o_fu_start_addr), .o_fu_stop_drain(o_fu_stop_drain),
        .i_fu_busy(i_fu_busy), .i_fetch_addr(i_fetch_addr), .i_fetch_data(i_fetch_data),
        .i_fetch_vld(i_fetch_vld), .i_fetch_err(i_fetch_err), .o_fetch_rd(o_fetch_rd),
        .o_cmd(o_cmd), .o_cmd_vld(o_cmd_vld), .i_cmd_rdy(i_cmd_rdy), .i_vpus_busy(i_vpus_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (o_cmd_vld && i_cmd_rdy) hs <= hs + 1;

    task automatic present(input logic [36:0] a, input logic [63:0] d, input logic e);
        i_fetch_vld = 1'b1; i_fetch_addr = a; i_fetch_data = d; i_fetch_err = e;
    endtask

    task automatic start_prog(input logic [36:0] a);
        @(negedge clk); i_start = 1'b1; i_start_addr = a; i_fetch_vld = 1'b0;
        @(negedge clk); i_start = 1'b0; i_fu_busy = 1'b1;
    endtask

    task automatic abort_to_idle;
        @(negedge clk); i_fetch_vld = 1'b0; i_cmd_rdy = 1'b1; i_abort = 1'b1;
        @(negedge clk); i_abort = 1'b0; i_fu_busy = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        #1;
        total++; if ({o_busy, o_done, o_err, o_err_code, o_err_addr, o_fu_start, o_fu_start_addr, o_fu_stop_drain, o_fetch_rd, o_cmd, o_cmd_vld} !== '0) begin
            bad++; $display("FAIL reset_outputs: busy=%b cmd=%h vld=%b", o_busy, o_cmd, o_cmd_vld); end
        @(negedge clk); nrst = 1'b1;
    endtask

    task automatic test_program;
        start_prog(37'h100);
        present(37'h100, VA, 1'b0); #1;
        total++; if ({o_fu_start, o_fu_start_addr} !== {1'b1, 37'h100}) begin
            bad++; $display("FAIL prog_fu_start: got %b/%h want 1/100", o_fu_start, o_fu_start_addr); end
        total++; if (o_fetch_rd !== 1'b1) begin bad++; $display("FAIL prog_pop_a: got %b want 1", o_fetch_rd); end
        @(negedge clk); present(37'h101, VB, 1'b0); #1;
        total++; if ({o_cmd_vld, o_cmd, o_fu_start} !== {1'b1, VA, 1'b0}) begin
            bad++; $display("FAIL prog_beat_a: got %b/%h want 1/%h", o_cmd_vld, o_cmd, VA); end
        @(negedge clk); present(37'h102, DONE, 1'b0); #1;
        total++; if ({o_cmd_vld, o_cmd, o_fetch_rd} !== {1'b1, VB, 1'b1}) begin
            bad++; $display("FAIL prog_beat_b: got %b/%h want 1/%h", o_cmd_vld, o_cmd, VB); end
        @(negedge clk); i_fetch_vld = 1'b0; #1;
        total++; if ({o_fu_stop_drain, o_cmd_vld, o_done} !== 3'b100) begin
            bad++; $display("FAIL prog_stop: got %b want 100", {o_fu_stop_drain, o_cmd_vld, o_done}); end
        @(negedge clk); i_fu_busy = 1'b0; #1;
        total++; if ({o_fu_stop_drain, o_done, o_busy} !== 3'b001) begin
            bad++; $display("FAIL prog_drain_wait: got %b want 001", {o_fu_stop_drain, o_done, o_busy}); end
        @(negedge clk); #1;
        total++; if ({o_done, o_err, o_busy} !== 3'b100) begin
            bad++; $display("FAIL prog_done: got %b want 100", {o_done, o_err, o_busy}); end
        @(negedge clk); #1;
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL prog_done_pulse: got %b want 0", o_done); end
    endtask

    task automatic test_jump;
        start_prog(37'h100);
        present(37'h105, JMP, 1'b0); #1;
        total++; if (o_fetch_rd !== 1'b1) begin bad++; $display("FAIL jmp_pop: got %b want 1", o_fetch_rd); end
        @(negedge clk); present(37'h106, VA, 1'b0); #1;
        total++; if ({o_fu_stop_drain, o_fetch_rd} !== 2'b10) begin
            bad++; $display("FAIL jmp_stop: got %b want 10", {o_fu_stop_drain, o_fetch_rd}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++; if ({o_fetch_rd, o_fu_start, o_cmd_vld} !== 3'b000) begin
                bad++; $display("FAIL jmp_drain_hold%0d: got %b want 000", i, {o_fetch_rd, o_fu_start, o_cmd_vld}); end
        end
        @(negedge clk); i_fu_busy = 1'b0; i_fetch_vld = 1'b0;
        @(negedge clk); #1;
        total++; if (o_fu_start !== 1'b0) begin bad++; $display("FAIL jmp_restart_early: got %b want 0", o_fu_start); end
        @(negedge clk); #1;
        total++; if ({o_fu_start, o_fu_start_addr} !== {1'b1, 37'h2000}) begin
            bad++; $display("FAIL jmp_restart: got %b/%h want 1/2000", o_fu_start, o_fu_start_addr); end
        abort_to_idle();
    endtask

    task automatic test_back_to_back;
        int h0;
        start_prog(37'h200);
        h0 = hs; i_cmd_rdy = 1'b0;
        present(37'h200, VA, 1'b0); #1;
        total++; if (o_fetch_rd !== 1'b1) begin bad++; $display("FAIL bp_pop_a: got %b want 1", o_fetch_rd); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); present(37'h201, VB, 1'b0); #1;
            total++; if ({o_fetch_rd, o_cmd_vld, o_cmd} !== {2'b01, VA}) begin
                bad++; $display("FAIL bp_hold%0d: got %b%b/%h want 01/%h", i, o_fetch_rd, o_cmd_vld, o_cmd, VA); end
        end
        @(negedge clk); i_cmd_rdy = 1'b1; #1;
        total++; if (o_fetch_rd !== 1'b1) begin bad++; $display("FAIL bp_pop_b: got %b want 1", o_fetch_rd); end
        @(negedge clk); i_fetch_vld = 1'b0; #1;
        total++; if ({o_cmd_vld, o_cmd} !== {1'b1, VB}) begin
            bad++; $display("FAIL bp_beat_b: got %b/%h want 1/%h", o_cmd_vld, o_cmd, VB); end
        @(negedge clk); #1;
        total++; if ({o_cmd_vld, hs - h0} !== {1'b0, 32'd2}) begin
            bad++; $display("FAIL bp_count: got vld=%b beats=%0d want 0/2", o_cmd_vld, hs - h0); end
        abort_to_idle();
    endtask

    task automatic test_sync;
        start_prog(37'h300);
        i_vpus_busy = 1'b1; present(37'h300, VA, 1'b0);
        @(negedge clk); present(37'h301, SYNC, 1'b0); #1;
        total++; if (o_fetch_rd !== 1'b1) begin bad++; $display("FAIL sync_pop: got %b want 1", o_fetch_rd); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); present(37'h302, VB, 1'b0); #1;
            total++; if (o_fetch_rd !== 1'b0) begin bad++; $display("FAIL sync_wait%0d: got %b want 0", i, o_fetch_rd); end
        end
        @(negedge clk); i_vpus_busy = 1'b0; #1;
        total++; if (o_fetch_rd !== 1'b0) begin bad++; $display("FAIL sync_release_early: got %b want 0", o_fetch_rd); end
        @(negedge clk); #1;
        total++; if (o_fetch_rd !== 1'b1) begin bad++; $display("FAIL sync_resume: got %b want 1", o_fetch_rd); end
        @(negedge clk); i_fetch_vld = 1'b0; #1;
        total++; if ({o_cmd_vld, o_cmd} !== {1'b1, VB}) begin
            bad++; $display("FAIL sync_dispatch: got %b/%h want 1/%h", o_cmd_vld, o_cmd, VB); end
        abort_to_idle();
    endtask

    task automatic test_errors;
        start_prog(37'h1E0);
        present(37'h1F0, VA, 1'b1); #1;
        total++; if (o_fetch_rd !== 1'b1) begin bad++; $display("FAIL ferr_pop: got %b want 1", o_fetch_rd); end
        @(negedge clk); i_fetch_vld = 1'b0; i_fu_busy = 1'b0; #1;
        total++; if ({o_fu_stop_drain, o_cmd_vld, o_err_code, o_err_addr} !== {2'b10, 2'b01, 37'h1F0}) begin
            bad++; $display("FAIL ferr_latch: got %b%b/%b/%h want 10/01/1f0", o_fu_stop_drain, o_cmd_vld, o_err_code, o_err_addr); end
        @(negedge clk); @(negedge clk); #1;
        total++; if ({o_err, o_done, o_busy} !== 3'b100) begin
            bad++; $display("FAIL ferr_pulse: got %b want 100", {o_err, o_done, o_busy}); end
        start_prog(37'h1F8);
        present(37'h1F8, ILL, 1'b0); #1;
        total++; if (o_fetch_rd !== 1'b1) begin bad++; $display("FAIL ill_pop: got %b want 1", o_fetch_rd); end
        @(negedge clk); i_fetch_vld = 1'b0; i_fu_busy = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        total++; if ({o_err, o_err_code, o_err_addr} !== {1'b1, 2'b10, 37'h1F8}) begin
            bad++; $display("FAIL ill_err: got %b/%b/%h want 1/10/1f8", o_err, o_err_code, o_err_addr); end
    endtask

    task automatic test_abort;
        start_prog(37'h400);
        present(37'h400, VA, 1'b0); i_abort = 1'b1; #1;
        total++; if (o_fetch_rd !== 1'b0) begin bad++; $display("FAIL abort_nopop: got %b want 0", o_fetch_rd); end
        @(negedge clk); i_abort = 1'b0; i_fetch_vld = 1'b0; i_fu_busy = 1'b0; #1;
        total++; if ({o_cmd_vld, o_fu_stop_drain, o_err_code} !== {2'b01, 2'b11}) begin
            bad++; $display("FAIL abort_latch: got %b%b/%b want 01/11", o_cmd_vld, o_fu_stop_drain, o_err_code); end
        @(negedge clk); @(negedge clk); #1;
        total++; if ({o_err, o_busy} !== 2'b10) begin bad++; $display("FAIL abort_err: got %b want 10", {o_err, o_busy}); end
        start_prog(37'h500);
        i_cmd_rdy = 1'b0; present(37'h500, VA, 1'b0);
        @(negedge clk); present(37'h501, VB, 1'b0); nrst = 1'b0; #1;
        total++; if ({o_busy, o_done, o_err, o_err_code, o_err_addr, o_fu_start, o_fu_start_addr, o_fu_stop_drain, o_fetch_rd, o_cmd, o_cmd_vld} !== '0) begin
            bad++; $display("FAIL midrun_reset: busy=%b rd=%b cmd=%h vld=%b eaddr=%h", o_busy, o_fetch_rd, o_cmd, o_cmd_vld, o_err_addr); end
        @(negedge clk); nrst = 1'b1; i_fetch_vld = 1'b0; i_cmd_rdy = 1'b1; i_fu_busy = 1'b0;
        @(negedge clk); #1;
        total++; if ({o_busy, o_fu_start} !== 2'b00) begin bad++; $display("FAIL reset_idle: got %b want 00", {o_busy, o_fu_start}); end
    endtask

    initial begin
        test_reset();
        test_program();
        test_jump();
        test_back_to_back();
        test_sync();
        test_errors();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
